// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   24-hour BCD clock with a button-driven set mode and blinking digit pairs.
//   Time advances one minute per tick pulse while running; btn_mode cycles
//   through the edit states and btn_inc bumps the field being edited.
//
//   Optional feature: define CLOCK_ALARM_EN to build in an alarm time, two
//   extra edit states for it, and the alarm output. Without the macro the
//   alarm output is tied low and no alarm registers exist.
//
// Parameters
//   BLINK_DIV   clk cycles per blink half-period (>= 2)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active low
//   tick           in   one-cycle pulse, advance time by one minute
//   btn_mode       in   one-cycle pulse, step to the next mode
//   btn_inc        in   one-cycle pulse, increment the selected field
//   hours_tens     out  BCD digit
//   hours_ones     out  BCD digit
//   minutes_tens   out  BCD digit
//   minutes_ones   out  BCD digit
//   day            out  one-cycle pulse on 23:59 -> 00:00 rollover
//   mode           out  RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4
//   blank_hr       out  blank the hour digits (blink)
//   blank_min      out  blank the minute digits (blink)
//   alarm          out  alarm level
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hours_tens,
    output logic [3:0] hours_ones,
    output logic [3:0] minutes_tens,
    output logic [3:0] minutes_ones,
    output logic       day,
    output logic [2:0] mode,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       alarm
);

    localparam logic [2:0] RUN      = 3'd0;
    localparam logic [2:0] SET_HR   = 3'd1;
    localparam logic [2:0] SET_MIN  = 3'd2;
    localparam logic [2:0] SET_AHR  = 3'd3;
    localparam logic [2:0] SET_AMIN = 3'd4;

    localparam int             CW      = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_DIV - 1);

    // Hours are kept as a packed BCD pair {tens, ones}; 23 wraps to 00.
    function automatic logic [7:0] inc_hours(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h23)
            r = 8'h00;
        else if (h[3:0] == 4'd9)
            r = {h[7:4] + 4'd1, 4'd0};
        else
            r = {h[7:4], h[3:0] + 4'd1};
        return r;
    endfunction

    // Minutes as a packed BCD pair; 59 wraps to 00 (carry handled by caller).
    function automatic logic [7:0] inc_minutes(input logic [7:0] m);
        logic [7:0] r;
        if (m[3:0] == 4'd9)
            r = (m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'd0};
        else
            r = {m[7:4], m[3:0] + 4'd1};
        return r;
    endfunction

    logic [7:0]    hr_q;
    logic [7:0]    mn_q;
    logic [2:0]    mode_q;
    logic [2:0]    mode_nxt;
    logic          day_q;
    logic [CW-1:0] cnt_q;
    logic          phase_q;

    logic          run;
    logic          tick_acc;
    logic          inc_acc;
    logic          mn_carry;
    logic [7:0]    hr_inc;
    logic [7:0]    mn_inc;
    logic          blink_clr;

    assign run       = (mode_q == RUN);
    assign tick_acc  = run & tick;
    // btn_inc is only meaningful in an edit state and loses to btn_mode.
    assign inc_acc   = btn_inc & ~btn_mode & ~run;
    assign mn_carry  = (mn_q == 8'h59);
    assign hr_inc    = inc_hours(hr_q);
    assign mn_inc    = inc_minutes(mn_q);
    // Restart the blink on every mode change and every accepted edit so the
    // freshly changed digits are visible immediately.
    assign blink_clr = btn_mode | inc_acc;

    always_comb begin
        mode_nxt = mode_q;
        if (btn_mode) begin
            case (mode_q)
                RUN:      mode_nxt = SET_HR;
                SET_HR:   mode_nxt = SET_MIN;
`ifdef CLOCK_ALARM_EN
                SET_MIN:  mode_nxt = SET_AHR;
                SET_AHR:  mode_nxt = SET_AMIN;
                SET_AMIN: mode_nxt = RUN;
`else
                SET_MIN:  mode_nxt = RUN;
`endif
                default:  mode_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= RUN;
        end else begin
            mode_q <= mode_nxt;
        end
    end

    // Time of day. Ticks and edits are mutually exclusive by mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hr_q  <= 8'h00;
            mn_q  <= 8'h00;
            day_q <= 1'b0;
        end else begin
            day_q <= 1'b0;
            if (tick_acc) begin
                mn_q <= mn_inc;
                if (mn_carry) begin
                    hr_q <= hr_inc;
                end
                day_q <= mn_carry & (hr_q == 8'h23);
            end else if (inc_acc && mode_q == SET_HR) begin
                hr_q <= hr_inc;
            end else if (inc_acc && mode_q == SET_MIN) begin
                mn_q <= mn_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (blink_clr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

`ifdef CLOCK_ALARM_EN
    logic [7:0] al_hr_q;
    logic [7:0] al_mn_q;
    logic       alarm_q;
    logic [7:0] al_hr_inc;
    logic [7:0] al_mn_inc;
    logic [7:0] hr_after_tick;
    logic       show_alarm;

    assign al_hr_inc     = inc_hours(al_hr_q);
    assign al_mn_inc     = inc_minutes(al_mn_q);
    assign hr_after_tick = mn_carry ? hr_inc : hr_q;
    assign show_alarm    = (mode_q == SET_AHR) | (mode_q == SET_AMIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            al_hr_q <= 8'h00;
            al_mn_q <= 8'h00;
            alarm_q <= 1'b0;
        end else begin
            if (inc_acc && mode_q == SET_AHR) begin
                al_hr_q <= al_hr_inc;
            end
            if (inc_acc && mode_q == SET_AMIN) begin
                al_mn_q <= al_mn_inc;
            end
            // The alarm fires on the minute change that lands on the alarm
            // time, and drops on the next minute change, a press, or mode exit.
            if (!run || btn_mode) begin
                alarm_q <= 1'b0;
            end else if (tick_acc) begin
                alarm_q <= ({hr_after_tick, mn_inc} == {al_hr_q, al_mn_q});
            end else if (btn_inc) begin
                alarm_q <= 1'b0;
            end
        end
    end

    assign hours_tens   = show_alarm ? al_hr_q[7:4] : hr_q[7:4];
    assign hours_ones   = show_alarm ? al_hr_q[3:0] : hr_q[3:0];
    assign minutes_tens = show_alarm ? al_mn_q[7:4] : mn_q[7:4];
    assign minutes_ones = show_alarm ? al_mn_q[3:0] : mn_q[3:0];
    assign alarm        = alarm_q;
`else
    assign hours_tens   = hr_q[7:4];
    assign hours_ones   = hr_q[3:0];
    assign minutes_tens = mn_q[7:4];
    assign minutes_ones = mn_q[3:0];
    assign alarm        = 1'b0;
`endif

    assign day       = day_q;
    assign mode      = mode_q;
    assign blank_hr  = phase_q & ((mode_q == SET_HR)  | (mode_q == SET_AHR));
    assign blank_min = phase_q & ((mode_q == SET_MIN) | (mode_q == SET_AMIN));

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//   Scoreboard bench for time_set_ctrl. The driver applies inputs on the
//   falling edge, steps a minute-count reference model and queues the
//   expected outputs; a monitor compares them shortly after each rising edge.
//   Builds with or without CLOCK_ALARM_EN.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int BD = 4;
`ifdef CLOCK_ALARM_EN
    localparam int NMODES = 5;
    localparam bit HAS_AL = 1'b1;
`else
    localparam int NMODES = 3;
    localparam bit HAS_AL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hours_tens, hours_ones, minutes_tens, minutes_ones;
    logic       day;
    logic [2:0] mode;
    logic       blank_hr, blank_min, alarm;

    time_set_ctrl #(.BLINK_DIV(BD)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .hours_tens   (hours_tens),
        .hours_ones   (hours_ones),
        .minutes_tens (minutes_tens),
        .minutes_ones (minutes_ones),
        .day          (day),
        .mode         (mode),
        .blank_hr     (blank_hr),
        .blank_min    (blank_min),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: time and alarm as minutes since midnight.
    int m_cur, m_al, m_mode, m_n;
    bit m_day, m_alarm;
    logic [22:0] exp_q[$];

    function automatic int bump_h(input int v);
        return ((v / 60 + 1) % 24) * 60 + v % 60;
    endfunction

    function automatic int bump_m(input int v);
        return (v / 60) * 60 + (v % 60 + 1) % 60;
    endfunction

    function automatic void model_reset();
        m_cur = 0; m_al = 0; m_mode = 0; m_n = 0; m_day = 0; m_alarm = 0;
    endfunction

    function automatic void model_step(input bit t, input bit m, input bit i);
        int old;
        bit clr;
        old = m_mode;
        clr = 1'b0;
        m_day = 1'b0;
        if (old == 0 && t) begin
            m_day = (m_cur == 1439);
            m_cur = (m_cur + 1) % 1440;
        end
        if (old == 0) begin
            if (m)      m_alarm = 1'b0;
            else if (t) m_alarm = HAS_AL && (m_cur == m_al);
            else if (i) m_alarm = 1'b0;
        end
        if (m) begin
            m_mode = (old + 1) % NMODES;
            clr = 1'b1;
        end else if (i && old != 0) begin
            clr = 1'b1;
            case (old)
                1: m_cur = bump_h(m_cur);
                2: m_cur = bump_m(m_cur);
                3: m_al  = bump_h(m_al);
                4: m_al  = bump_m(m_al);
                default: ;
            endcase
        end
        m_n = clr ? 0 : m_n + 1;
    endfunction

    function automatic logic [22:0] model_out();
        int v, h, mi;
        bit ph;
        v  = (m_mode >= 3) ? m_al : m_cur;
        h  = v / 60;
        mi = v % 60;
        ph = ((m_n / BD) % 2) == 1;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), m_day,
                3'(m_mode), ph && (m_mode == 1 || m_mode == 3),
                ph && (m_mode == 2 || m_mode == 4), m_alarm};
    endfunction

    function automatic logic [22:0] dut_out();
        return {hours_tens, hours_ones, minutes_tens, minutes_ones, day,
                mode, blank_hr, blank_min, alarm};
    endfunction

    task automatic direct_check(input string name);
        logic [22:0] got, want;
        got  = dut_out();
        want = model_out();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic drive(input bit t, input bit m, input bit i);
        tick = t; btn_mode = m; btn_inc = i;
        model_step(t, m, i);
        exp_q.push_back(model_out());
    endtask

    task automatic cyc(input bit t, input bit m, input bit i);
        @(negedge clk);
        drive(t, m, i);
    endtask

    task automatic goto_mode(input int target);
        for (int k = 0; k < 6 && m_mode != target; k++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_hours(input int h);
        goto_mode(1);
        repeat ((h - m_cur / 60 + 24) % 24) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_mins(input int mm);
        goto_mode(2);
        repeat ((mm - m_cur % 60 + 60) % 60) cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: one expected entry per driven cycle, checked after the edge.
    initial begin
        logic [22:0] e, g;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_out();
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got=%h want=%h (digits,day,mode,bh,bm,alarm)",
                             $time, g, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        direct_check("reset_state");

        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // Full day of ticks, then rollover with a single-cycle day pulse.
        repeat (1439) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Hour wrap 20 -> 01 and minute wrap 58 -> 01 without hour carry.
        set_mins(58);
        set_hours(20);
        goto_mode(0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);

        // Ticks dropped while editing; mode+inc together steps only.
        goto_mode(1);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);

        // Blink in SET_MIN and restart on an edit.
        repeat (12) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);

        // Tick and mode together in RUN.
        goto_mode(0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-edit at 12:34.
        set_hours(12);
        set_mins(34);
        cyc(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        direct_check("async_reset_no_edge");
        repeat (2) @(negedge clk);
        direct_check("reset_held");
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

`ifdef CLOCK_ALARM_EN
        goto_mode(3);
        repeat ((6 - m_al / 60 + 24) % 24) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        repeat ((30 - m_al % 60 + 60) % 60) cyc(1'b0, 1'b0, 1'b1);
        set_hours(6);
        set_mins(29);
        goto_mode(0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom % 3) == 0, ($urandom % 16) == 0, ($urandom % 4) == 0);
        end
        cyc(1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (>=2).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have ports: tick  in  1  one-cycle pulse, advance time by one minute.
REQ-005 SHALL have ports: btn_mode  in  1  one-cycle pulse, already debounced/synchronized, step mode.
REQ-006 SHALL have ports: btn_inc  in  1  one-cycle pulse, already debounced/synchronized, increment selected field.
REQ-007 SHALL have ports: hours_tens, hours_ones, minutes_tens, minutes_ones  out  4 each  BCD display digits.
REQ-008 SHALL have ports: day  out  1  one-cycle pulse on 23:59->00:00 rollover.
REQ-009 SHALL have ports: mode  out  3  state code: RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4.
REQ-010 SHALL have ports: blank_hr, blank_min  out  1 each  digit-pair blanking for blink.
REQ-011 SHALL have ports: alarm  out  1  alarm level.

Function
REQ-012 SHALL hold time as four registered BCD digits, always valid 00:00..23:59; hours_ones max 3 when hours_tens=2, else 9.
REQ-013 SHALL implement FSM RUN -> SET_HR -> SET_MIN -> RUN, stepping one state per btn_mode pulse.
REQ-014 SHALL, in RUN, on tick: increment minutes; 59 -> 00 with carry to hours; 23:59 -> 00:00 with day=1 the following cycle only.
REQ-015 SHALL, in SET_HR, on btn_inc: hours +1, 23 -> 00, minutes untouched, no day pulse.
REQ-016 SHALL, in SET_MIN, on btn_inc: minutes +1, 59 -> 00, no carry into hours.
REQ-017 SHALL ignore (drop, not queue) tick in every state other than RUN.
REQ-018 SHALL, when btn_mode and btn_inc coincide, apply the mode step and discard btn_inc.
REQ-019 SHALL, when tick and btn_mode coincide in RUN, apply the tick and take the transition in the same cycle.
REQ-020 SHALL update all outputs registered, one cycle after the causing input edge.
REQ-021 SHALL run a blink counter 0..BLINK_DIV-1 toggling a phase bit at wrap; counter and phase cleared on every state change and every accepted btn_inc.
REQ-022 SHALL drive blank_hr = phase and (mode is SET_HR or SET_AHR); blank_min = phase and (mode is SET_MIN or SET_AMIN); both 0 in RUN.
REQ-023 SHALL ignore btn_inc in RUN (except REQ-028).

Reset
REQ-024 SHALL, while rst=0, force: all digits 0, day=0, mode=RUN, blank_hr=blank_min=0, blink counter/phase 0, alarm=0, alarm time 00:00.
REQ-025 SHALL, on reset mid-set, abandon the edit and return to RUN at 00:00; first tick after release gives 00:01.

Configuration
REQ-026 SHALL compile alarm feature only when macro CLOCK_ALARM_EN is defined.
REQ-027 SHALL, with CLOCK_ALARM_EN, extend FSM SET_MIN -> SET_AHR -> SET_AMIN -> RUN; in SET_AHR/SET_AMIN digits show alarm time; btn_inc edits alarm hours/minutes per REQ-015/016 rules; time keeps 00:00-valid and is not advanced (REQ-017).
REQ-028 SHALL, with CLOCK_ALARM_EN, set alarm=1 when in RUN and time first equals alarm time; clear on btn_inc in RUN, on next minute change, or on leaving RUN.
REQ-029 SHALL, without CLOCK_ALARM_EN, tie alarm=0, omit alarm registers, and never produce mode codes 3 or 4.

Verification
REQ-030 SHALL cover: reset, 1439 ticks in RUN -> 23:59, day=0; one more tick -> 00:00, day=1 for exactly one cycle.
REQ-031 SHALL cover: btn_mode, 5x btn_inc at 20:xx -> hours 01; btn_mode, 3x btn_inc at minutes 58 -> minutes 01, hours still 01.
REQ-032 SHALL cover: 10 ticks during SET_HR -> time unchanged; btn_mode+btn_inc same cycle -> mode steps, value unchanged.
REQ-033 SHALL cover: BLINK_DIV=4 in SET_MIN -> blank_min toggles every 4 cycles, blank_hr=0; btn_inc -> blank_min=0 next cycle.
REQ-034 SHALL cover: rst=0 asserted between clock edges in SET_MIN at 12:34 -> outputs 00:00, mode=0 immediately, without a clock edge.
REQ-035 SHALL cover (CLOCK_ALARM_EN): alarm set 06:30, time 06:29, one tick -> alarm=1; btn_inc -> alarm=0.
